// File: rtl/vram_pkg.sv
// Shared types for the VRAM arbiter: fetch FSM states, RAM slot owner, line-buffer index width.
package vram_pkg;

  typedef enum logic {IDLE = 1'b0, FETCH = 1'b1} state_e;

  typedef enum logic [1:0] {NONE = 2'd0, VID = 2'd1, HOST = 2'd2} slot_e;

  // Index width for a line buffer of `words` entries (never narrower than one bit).
  function automatic int lb_idx_w(input int words);
    return (words > 2) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/vram_fetch_ctr.sv
// Scanline burst sequencer: latches the line base address and walks the word index
// while the fetch FSM is in FETCH.
module vram_fetch_ctr
  import vram_pkg::*;
#(
  parameter int ADDR_W         = 14,
  parameter int WORDS_PER_LINE = 16,
  parameter int LB_IDX_W       = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic [8:0]          line_idx_i,
  input  logic                adv_i,
  output logic                active_o,
  output logic [LB_IDX_W-1:0] idx_o,
  output logic [ADDR_W-1:0]   addr_o
);

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     base_q, base_d;
  logic [LB_IDX_W-1:0]   idx_q, idx_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      base_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    idx_d   = idx_q;
    // A new line start always wins: any burst in flight is abandoned.
    if (start_i) begin
      state_d = FETCH;
      base_d  = ADDR_W'({line_idx_i, {LB_IDX_W{1'b0}}});
      idx_d   = '0;
    end else if (state_q == FETCH && adv_i) begin
      if (idx_q == LB_IDX_W'(WORDS_PER_LINE - 1)) begin
        state_d = IDLE;
        idx_d   = '0;
      end else begin
        idx_d = idx_q + LB_IDX_W'(1);
      end
    end
  end

  assign active_o = (state_q == FETCH);
  assign idx_o    = idx_q;
  assign addr_o   = base_q + ADDR_W'(idx_q);

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: scanline prefetch bursts have priority over host accesses,
// except when the host has been starved for HOST_MAX_WAIT cycles.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int ADDR_W         = 14,
  parameter int DATA_W         = 16,
  parameter int WORDS_PER_LINE = 16,
  parameter int HOST_MAX_WAIT  = 8
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              line_start_i,
  input  logic [8:0]                        line_idx_i,
  output logic                              vid_we_o,
  output logic [$clog2(WORDS_PER_LINE)-1:0] vid_waddr_o,
  output logic [DATA_W-1:0]                 vid_wdata_o,
  output logic                              underrun_o,
  input  logic                              host_req_i,
  input  logic                              host_we_i,
  input  logic [ADDR_W-1:0]                 host_addr_i,
  input  logic [DATA_W-1:0]                 host_wdata_i,
  output logic                              host_gnt_o,
  output logic                              host_rvalid_o,
  output logic [DATA_W-1:0]                 host_rdata_o,
  output logic                              mem_en_o,
  output logic                              mem_we_o,
  output logic [ADDR_W-1:0]                 mem_addr_o,
  output logic [DATA_W-1:0]                 mem_wdata_o,
  input  logic [DATA_W-1:0]                 mem_rdata_i
);

  localparam int LB_IDX_W = lb_idx_w(WORDS_PER_LINE);
  localparam int WAIT_W   = $clog2(HOST_MAX_WAIT + 1);

  logic                fetch_active;
  logic [LB_IDX_W-1:0] fetch_idx;
  logic [ADDR_W-1:0]   fetch_addr;
  slot_e               slot;

  logic [WAIT_W-1:0]   wait_q, wait_d;
  slot_e               tag_slot_q, tag_slot_d;
  logic [LB_IDX_W-1:0] tag_idx_q, tag_idx_d;
  logic                underrun_q, underrun_d;

  vram_fetch_ctr #(
    .ADDR_W        (ADDR_W),
    .WORDS_PER_LINE(WORDS_PER_LINE),
    .LB_IDX_W      (LB_IDX_W)
  ) u_fetch (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .start_i   (line_start_i),
    .line_idx_i(line_idx_i),
    .adv_i     (slot == VID),
    .active_o  (fetch_active),
    .idx_o     (fetch_idx),
    .addr_o    (fetch_addr)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wait_q     <= '0;
      tag_slot_q <= NONE;
      tag_idx_q  <= '0;
      underrun_q <= 1'b0;
    end else begin
      wait_q     <= wait_d;
      tag_slot_q <= tag_slot_d;
      tag_idx_q  <= tag_idx_d;
      underrun_q <= underrun_d;
    end
  end

  // Slot select; held at NONE during reset so the RAM sees no access.
  always_comb begin
    slot = NONE;
    if (rst_ni) begin
      if (host_req_i && wait_q == WAIT_W'(HOST_MAX_WAIT)) slot = HOST;
      else if (fetch_active)                               slot = VID;
      else if (host_req_i)                                 slot = HOST;
    end
  end

  always_comb begin
    mem_en_o    = (slot != NONE);
    mem_we_o    = (slot == HOST) && host_we_i;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (slot == VID)  mem_addr_o = fetch_addr;
    if (slot == HOST) mem_addr_o = host_addr_i;
    if (mem_we_o)     mem_wdata_o = host_wdata_i;
  end

  always_comb begin
    wait_d = '0;
    if (host_req_i && slot != HOST)
      wait_d = (wait_q == WAIT_W'(HOST_MAX_WAIT)) ? wait_q : wait_q + WAIT_W'(1);
    tag_slot_d = NONE;
    if (slot == VID)                     tag_slot_d = VID;
    else if (slot == HOST && !host_we_i) tag_slot_d = HOST;
    tag_idx_d  = fetch_idx;
    underrun_d = line_start_i && fetch_active;
  end

  assign host_gnt_o    = (slot == HOST);
  assign vid_we_o      = (tag_slot_q == VID);
  assign vid_waddr_o   = vid_we_o ? tag_idx_q : '0;
  assign vid_wdata_o   = vid_we_o ? mem_rdata_i : '0;
  assign host_rvalid_o = (tag_slot_q == HOST);
  assign host_rdata_o  = host_rvalid_o ? mem_rdata_i : '0;
  assign underrun_o    = underrun_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Randomized bench for vram_arbiter against a transaction-level model of the slot rules.
module tb_vram_arbiter;

  localparam int AW  = 12;
  localparam int DW  = 16;
  localparam int WPL = 16;
  localparam int HMW = 8;
  localparam int MSZ = 1 << AW;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          line_start_i;
  logic [8:0]    line_idx_i;
  logic          vid_we_o;
  logic [3:0]    vid_waddr_o;
  logic [DW-1:0] vid_wdata_o;
  logic          underrun_o;
  logic          host_req_i, host_we_i;
  logic [AW-1:0] host_addr_i;
  logic [DW-1:0] host_wdata_i;
  logic          host_gnt_o, host_rvalid_o;
  logic [DW-1:0] host_rdata_o;
  logic          mem_en_o, mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [DW-1:0] mem_rdata_i;

  always #5 clk_i = ~clk_i;

  vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WORDS_PER_LINE(WPL), .HOST_MAX_WAIT(HMW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .line_start_i(line_start_i), .line_idx_i(line_idx_i),
    .vid_we_o(vid_we_o), .vid_waddr_o(vid_waddr_o), .vid_wdata_o(vid_wdata_o),
    .underrun_o(underrun_o), .host_req_i(host_req_i), .host_we_i(host_we_i),
    .host_addr_i(host_addr_i), .host_wdata_i(host_wdata_i), .host_gnt_o(host_gnt_o),
    .host_rvalid_o(host_rvalid_o), .host_rdata_o(host_rdata_o), .mem_en_o(mem_en_o),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i)
  );

  function automatic logic [DW-1:0] pat(input int a);
    return DW'(a * 16'h1357) ^ 16'h00A5;
  endfunction

  // RAM macro: unwritten words read back a fixed pattern.
  logic [DW-1:0] ram [MSZ];
  bit            ram_wr [MSZ];
  always @(posedge clk_i) begin
    if (mem_en_o) begin
      if (mem_we_o) begin
        ram[mem_addr_o]    <= mem_wdata_o;
        ram_wr[mem_addr_o] <= 1'b1;
      end else begin
        mem_rdata_i <= ram_wr[mem_addr_o] ? ram[mem_addr_o] : pat(int'(mem_addr_o));
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a count of words still owed to the line buffer plus a shadow RAM.
  logic [DW-1:0] shadow [MSZ];
  bit            sh_wr [MSZ];
  int            m_left, m_k, m_base, m_wait;
  bit            m_gnt, host_rand_en;
  bit            e_vwe, e_rv, e_ur;
  int            e_vidx;
  logic [DW-1:0] e_vdata, e_rdata;

  function automatic logic [DW-1:0] sh_rd(input int a);
    return sh_wr[a] ? shadow[a] : pat(a);
  endfunction

  task automatic model_reset();
    m_left = 0; m_k = 0; m_base = 0; m_wait = 0; m_gnt = 0;
    e_vwe = 0; e_rv = 0; e_ur = 0; e_vidx = 0; e_vdata = '0; e_rdata = '0;
  endtask

  task automatic model_check();
    int s;
    int va;
    chk("vid_we", vid_we_o, e_vwe);
    if (e_vwe) begin
      chk("vid_waddr", vid_waddr_o, e_vidx);
      chk("vid_wdata", vid_wdata_o, e_vdata);
    end
    chk("host_rvalid", host_rvalid_o, e_rv);
    if (e_rv) chk("host_rdata", host_rdata_o, e_rdata);
    chk("underrun", underrun_o, e_ur);

    s = 0;
    if (host_req_i && m_wait >= HMW) s = 2;
    else if (m_left > 0)             s = 1;
    else if (host_req_i)             s = 2;
    va = (m_base + m_k) % MSZ;
    chk("mem_en", mem_en_o, s != 0);
    chk("host_gnt", host_gnt_o, s == 2);
    chk("mem_we", mem_we_o, s == 2 && host_we_i);
    if (s == 1) chk("mem_addr_vid", mem_addr_o, va);
    if (s == 2) chk("mem_addr_host", mem_addr_o, host_addr_i);
    if (s == 2 && host_we_i) chk("mem_wdata", mem_wdata_o, host_wdata_i);

    e_vwe   = (s == 1);
    e_vidx  = m_k;
    e_vdata = sh_rd(va);
    e_rv    = (s == 2) && !host_we_i;
    e_rdata = sh_rd(int'(host_addr_i));
    if (s == 2 && host_we_i) begin
      shadow[host_addr_i] = host_wdata_i;
      sh_wr[host_addr_i]  = 1'b1;
    end
    e_ur = line_start_i && (m_left > 0);
    if (s == 1) begin m_left--; m_k++; end
    m_wait = (host_req_i && s != 2) ? ((m_wait < HMW) ? m_wait + 1 : HMW) : 0;
    if (line_start_i) begin
      m_left = WPL; m_k = 0; m_base = (int'(line_idx_i) * WPL) % MSZ;
    end
    m_gnt = (s == 2);
  endtask

  // One clock: inputs held through the cycle, checked on the falling edge.
  task automatic step(input logic ls, input logic [8:0] li);
    line_start_i = ls;
    line_idx_i   = li;
    @(negedge clk_i);
    model_check();
    @(posedge clk_i);
    #1;
    line_start_i = 1'b0;
    if (host_req_i && m_gnt) host_req_i = 1'b0;
    if (host_rand_en && !host_req_i && ($urandom % 3 == 0)) begin
      host_req_i   = 1'b1;
      host_we_i    = 1'($urandom % 2);
      host_addr_i  = AW'($urandom % 64);
      host_wdata_i = DW'($urandom);
    end
  endtask

  task automatic host_op(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit done;
    done = 0;
    host_req_i = 1'b1; host_we_i = we; host_addr_i = a; host_wdata_i = d;
    for (int n = 0; n < 40 && !done; n++) begin
      step(1'b0, 9'd0);
      done = m_gnt;
    end
    if (!done) begin
      chk("host_timeout", 0, 1);
      host_req_i = 1'b0;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_mem_en"}, mem_en_o, 0);
    chk({tag, "_mem_addr"}, mem_addr_o, 0);
    chk({tag, "_host_gnt"}, host_gnt_o, 0);
    chk({tag, "_vid_we"}, vid_we_o, 0);
    chk({tag, "_rvalid"}, host_rvalid_o, 0);
    chk({tag, "_underrun"}, underrun_o, 0);
  endtask

  initial begin
    int n, gstep;
    rst_ni = 1'b0; line_start_i = 1'b0; line_idx_i = '0;
    host_req_i = 1'b0; host_we_i = 1'b0; host_addr_i = '0; host_wdata_i = '0;
    host_rand_en = 0;
    model_reset();
    repeat (3) @(posedge clk_i);
    #1;
    chk_zero("reset");
    rst_ni = 1'b1;
    step(1'b0, 9'd0); step(1'b0, 9'd0);

    // Line 3: reads 48..63 back to back.
    step(1'b1, 9'd3);
    chk("line3_base", mem_addr_o, 48);
    repeat (18) step(1'b0, 9'd0);

    host_op(1'b1, 12'h100, 16'hBEEF);
    host_op(1'b0, 12'h100, 16'h0000);
    chk("beef_rvalid", host_rvalid_o, 1);
    chk("beef_rdata", host_rdata_o, 16'hBEEF);
    step(1'b0, 9'd0);

    // Host held through a burst: forced slot after HMW denials.
    step(1'b1, 9'd5);
    host_req_i = 1'b1; host_we_i = 1'b0; host_addr_i = 12'h020;
    n = 0; gstep = 0;
    while (m_left > 0 && n < 40) begin
      step(1'b0, 9'd0);
      n++;
      if (m_gnt && gstep == 0) gstep = n;
    end
    chk("forced_gnt_cycle", gstep, HMW + 1);
    chk("forced_burst_len", n, WPL + 1);
    step(1'b0, 9'd0); step(1'b0, 9'd0);

    // Restart ten cycles into a burst.
    step(1'b1, 9'd2);
    repeat (9) step(1'b0, 9'd0);
    step(1'b1, 9'd7);
    chk("underrun_pulse", underrun_o, 1);
    chk("restart_base", mem_addr_o, 7 * WPL);
    repeat (18) step(1'b0, 9'd0);

    // Base wraps at the top of the address space.
    step(1'b1, 9'd511);
    chk("wrap_base", mem_addr_o, 12'hFF0);
    repeat (15) step(1'b0, 9'd0);
    chk("wrap_last", mem_addr_o, 12'hFFF);
    repeat (3) step(1'b0, 9'd0);

    // Asynchronous reset in the middle of a burst.
    step(1'b1, 9'd9);
    repeat (5) step(1'b0, 9'd0);
    #2 rst_ni = 1'b0;
    #1 chk_zero("midrst");
    model_reset();
    host_req_i = 1'b0;
    @(posedge clk_i); @(posedge clk_i);
    #1 rst_ni = 1'b1;
    repeat (4) step(1'b0, 9'd0);

    host_rand_en = 1;
    repeat (3000) step(1'($urandom % 40 == 0), 9'($urandom % 512));
    host_rand_en = 0;
    repeat (40) step(1'b0, 9'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
